multi_octave_tone_gen: RTL and testbench
========================================

# multi_octave_tone_gen

Parametrised square-wave tone generator for the FPGA audio path; it drives `speaker` directly. It takes clean single-cycle step pulses from the button input conditioner and selects among `NUM_OCTAVES` octaves of a base pitch. Over a single-note octave changer it adds up/down stepping with a wrap or saturate mode, selectable duty cycle, and a warble mode. Octave and duty changes take effect only at period boundaries, so the waveform never glitches.

## Interface
- `CLK_HZ`, default 25000000: system clock frequency.
- `BASE_HZ`, default 220: octave-0 frequency.
- `NUM_OCTAVES`, default 4: number of octaves, ≥2.
- `WRAP`, default 0: 1 = octave index wraps at either end; 0 = saturates.
- `WARBLE_PERIODS`, default 4096: tone periods spent on each half of the warble alternation.
- `CNT_W`, default 17: period counter width; must hold `CLK_HZ/BASE_HZ - 1`.
- `OCT_W`, default 2: octave index width; `2**OCT_W ≥ NUM_OCTAVES`.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: tone enable.
- `oct_up` input 1: single-cycle pulse; requests octave+1.
- `oct_dn` input 1: single-cycle pulse; requests octave−1.
- `duty_sel` input 2: 0 = 50%, 1 = 25%, 2 = 12.5%, 3 = 50%.
- `warble` input 1: enables octave alternation.
- `speaker` output 1: audio square wave (registered).
- `octave` output OCT_W: selected octave (registered).
- `act_octave` output OCT_W: octave currently being played (registered).
- `period_start` output 1: one-cycle pulse after each period boundary.

## Operation
- Period for octave k is `P_k = (CLK_HZ/BASE_HZ) >> k`. Integer division is done at elaboration. Precondition: `P_(NUM_OCTAVES-1) ≥ 8`.
- High time `H = P>>1`, `P>>2` or `P>>3`, per the latched duty.
- Selected octave register `octave`:
  - `oct_up` alone: +1.
  - `oct_dn` alone: −1.
  - Both asserted together: no change.
  - At the top (`NUM_OCTAVES-1`), an up step goes to 0 if WRAP, else holds. At 0, a down step goes to `NUM_OCTAVES-1` if WRAP, else holds.
  - Steps are accepted whether or not `en` is high.
- Effective target octave T:
  - T = `octave` when `warble`=0 or the warble phase is 0.
  - T = `octave+1` when the phase is 1, except T = `octave−1` when `octave` is the top octave.
- Period counter `cnt`:
  - `en`=0: `cnt`←0.
  - `en`=1: `cnt`←0 if `cnt==P_act−1`, else `cnt+1`.
- Boundary event B = `en && cnt==P_act−1`.
- On B, or on any cycle with `en`=0: `act_octave`←T and the active duty←`duty_sel`.
- Warble:
  - A period counter counts B events while `warble`=1.
  - On reaching `WARBLE_PERIODS`, the period counter clears and the phase toggles.
  - `warble`=0 clears both the period counter and the phase.
- Outputs:
  - `speaker` ← `en && cnt < H_act`.
  - `period_start` ← B.

## Timing
- Reset (async assert, sync-release tolerant): `speaker`=0, `octave`=0, `act_octave`=0, `period_start`=0, `cnt`=0, warble phase=0, warble period counter=0.
- Asserting `rst_n`=0 mid-tone forces `speaker` low immediately, without waiting for a clock edge.
- `octave` updates on the edge that samples the step pulse.
- `act_octave` follows within one edge while `en`=0. While `en`=1 it follows on the edge that samples B, which is the last cycle of the current period.
- `speaker` lags `cnt` by one edge:
  - First edge with `en`=1: `speaker`=1.
  - `en` falling: `speaker`=0 on the next edge.
  - Waveform period is exactly `P_act` clocks, with exactly `H_act` clocks high.
- `period_start` is high for one cycle, on the edge after B.

## Test plan
Bench parameters: `CLK_HZ=6400`, `BASE_HZ=100`, so `P` = 64/32/16/8.
1. Reset, then `en`=1, `duty_sel`=0 → `speaker` alternates 32 high / 32 low; `period_start` pulses every 64 cycles.
2. `oct_up` pulse at cycle 10 of a period → `octave`=1 on the next edge; `act_octave` stays 0 until the boundary; the following periods are 32 cycles, 16 high.
3. With WRAP=0, five `oct_up` pulses → `octave`=3; then `oct_up`+`oct_dn` in the same cycle → stays 3. With WRAP=1, five `oct_up` pulses from 0 → `octave`=1.
4. `octave`=2, `duty_sel`=1 → 16-cycle period, 4 high. Switch `duty_sel`=2 mid-period → the current period keeps 4 high, the next has 2 high.
5. `WARBLE_PERIODS=2`, `octave`=3, `warble`=1 → period lengths repeat 8, 8, 16, 16; `warble`=0 → back to 8 after the current period.
6. `rst_n`=0 during a high phase → `speaker`=0 at once, before any clock edge; `octave`=0. Release with `en`=1 → 64-cycle periods restart from `cnt`=0.

Source files
------------

// File: rtl/multi_octave_tone_gen.sv
// -----------------------------------------------------------------------------
// multi_octave_tone_gen
//
// Square-wave tone generator covering NUM_OCTAVES octaves of BASE_HZ. The
// selected octave is stepped up/down by single-cycle pulses, either wrapping
// or saturating at the ends. The octave and duty cycle actually being played
// are latched only at period boundaries (or whenever the tone is disabled),
// so the waveform never glitches. Warble mode alternates between the
// selected octave and a neighbour every WARBLE_PERIODS tone periods.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   en           : tone enable
//   oct_up       : single-cycle pulse, request octave + 1
//   oct_dn       : single-cycle pulse, request octave - 1
//   duty_sel     : 0 = 50%, 1 = 25%, 2 = 12.5%, 3 = 50%
//   warble       : enable octave alternation
//   speaker      : registered square-wave output
//   octave       : registered selected octave
//   act_octave   : registered octave currently being played
//   period_start : one-cycle pulse on the edge after each period boundary
// -----------------------------------------------------------------------------
module multi_octave_tone_gen #(
    parameter int CLK_HZ         = 25000000,
    parameter int BASE_HZ        = 220,
    parameter int NUM_OCTAVES    = 4,
    parameter int WRAP           = 0,
    parameter int WARBLE_PERIODS = 4096,
    parameter int CNT_W          = 17,
    parameter int OCT_W          = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             oct_up,
    input  logic             oct_dn,
    input  logic [1:0]       duty_sel,
    input  logic             warble,
    output logic             speaker,
    output logic [OCT_W-1:0] octave,
    output logic [OCT_W-1:0] act_octave,
    output logic             period_start
);

    // Octave-0 period in clocks, resolved at elaboration.
    localparam int unsigned      P0   = CLK_HZ / BASE_HZ;
    localparam logic [CNT_W-1:0] P0_C = CNT_W'(P0);
    localparam logic [OCT_W-1:0] TOP  = OCT_W'(NUM_OCTAVES - 1);
    localparam int               WCW  = (WARBLE_PERIODS > 1) ? $clog2(WARBLE_PERIODS) : 1;
    localparam logic [WCW-1:0]   WLAST = WCW'(WARBLE_PERIODS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OCT_W-1:0] octave_q, octave_d;
    logic [OCT_W-1:0] act_q, act_d;
    logic [1:0]       duty_q, duty_d;
    logic             speaker_q, speaker_d;
    logic             pstart_q, pstart_d;
    logic             wphase_q, wphase_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;

    logic [CNT_W-1:0] p_act;
    logic [CNT_W-1:0] h_act;
    logic [OCT_W-1:0] tgt;
    logic             last;
    logic             bnd;
    logic             up_only;
    logic             dn_only;

    always_comb begin
        p_act = P0_C >> act_q;
        case (duty_q)
            2'd1:    h_act = p_act >> 2;
            2'd2:    h_act = p_act >> 3;
            default: h_act = p_act >> 1;
        endcase

        last = (cnt_q == p_act - CNT_W'(1));
        bnd  = en && last;

        // Counter restarts every period and is held at zero while disabled.
        if (!en || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Simultaneous up and down cancel out.
        up_only  = oct_up && !oct_dn;
        dn_only  = oct_dn && !oct_up;
        octave_d = octave_q;
        if (up_only) begin
            if (octave_q == TOP) begin
                octave_d = (WRAP != 0) ? '0 : TOP;
            end else begin
                octave_d = octave_q + OCT_W'(1);
            end
        end else if (dn_only) begin
            if (octave_q == '0) begin
                octave_d = (WRAP != 0) ? TOP : '0;
            end else begin
                octave_d = octave_q - OCT_W'(1);
            end
        end

        // Warble partner is one octave up, or one down from the top octave.
        tgt = octave_q;
        if (warble && wphase_q) begin
            tgt = (octave_q == TOP) ? octave_q - OCT_W'(1) : octave_q + OCT_W'(1);
        end

        // Played octave/duty only change at a boundary or while silent.
        act_d  = act_q;
        duty_d = duty_q;
        if (bnd || !en) begin
            act_d  = tgt;
            duty_d = duty_sel;
        end

        wcnt_d   = wcnt_q;
        wphase_d = wphase_q;
        if (!warble) begin
            wcnt_d   = '0;
            wphase_d = 1'b0;
        end else if (bnd) begin
            if (wcnt_q == WLAST) begin
                wcnt_d   = '0;
                wphase_d = !wphase_q;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
            end
        end

        speaker_d = en && (cnt_q < h_act);
        pstart_d  = bnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            octave_q  <= '0;
            act_q     <= '0;
            duty_q    <= 2'd0;
            speaker_q <= 1'b0;
            pstart_q  <= 1'b0;
            wphase_q  <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            octave_q  <= octave_d;
            act_q     <= act_d;
            duty_q    <= duty_d;
            speaker_q <= speaker_d;
            pstart_q  <= pstart_d;
            wphase_q  <= wphase_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign speaker      = speaker_q;
    assign octave       = octave_q;
    assign act_octave   = act_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_multi_octave_tone_gen.sv
module tb_multi_octave_tone_gen;

    logic       clk;
    logic       rst_n;

    // saturating instance (also used for warble)
    logic       en;
    logic       oct_up;
    logic       oct_dn;
    logic [1:0] duty_sel;
    logic       warble;
    logic       speaker;
    logic [1:0] octave;
    logic [1:0] act_octave;
    logic       period_start;

    // wrapping instance
    logic       w_up;
    logic       w_dn;
    logic       w_speaker;
    logic [1:0] w_octave;
    logic [1:0] w_act_octave;
    logic       w_period_start;

    int total = 0;
    int bad   = 0;

    multi_octave_tone_gen #(
        .CLK_HZ(6400), .BASE_HZ(100), .NUM_OCTAVES(4), .WRAP(0),
        .WARBLE_PERIODS(2), .CNT_W(7), .OCT_W(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .oct_up(oct_up), .oct_dn(oct_dn),
        .duty_sel(duty_sel), .warble(warble), .speaker(speaker), .octave(octave),
        .act_octave(act_octave), .period_start(period_start)
    );

    multi_octave_tone_gen #(
        .CLK_HZ(6400), .BASE_HZ(100), .NUM_OCTAVES(4), .WRAP(1),
        .WARBLE_PERIODS(2), .CNT_W(7), .OCT_W(2)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(1'b0), .oct_up(w_up), .oct_dn(w_dn),
        .duty_sel(2'd0), .warble(1'b0), .speaker(w_speaker), .octave(w_octave),
        .act_octave(w_act_octave), .period_start(w_period_start)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Step pulse on one instance; returns at the negedge after the sampling edge.
    task automatic pulse(input bit wrap_inst, input bit up, input bit dn);
        @(negedge clk);
        if (wrap_inst) begin w_up = up; w_dn = dn; end
        else begin oct_up = up; oct_dn = dn; end
        @(negedge clk);
        w_up = 1'b0; w_dn = 1'b0; oct_up = 1'b0; oct_dn = 1'b0;
    endtask

    // Advance to the next negedge at which period_start is high.
    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 300);
        if (n >= 300) chk("wait_ps_timeout", n, 0);
    endtask

    // Starting at a negedge where period_start is high, measure one period
    // (length and high count). Optionally change duty_sel part way through.
    task automatic measure(output int len, output int hi, input int sw_at, input logic [1:0] sw_val);
        len = 0;
        hi  = 0;
        do begin
            if (len == sw_at) duty_sel = sw_val;
            hi += int'(speaker);
            len++;
            @(negedge clk);
        end while (!period_start && len < 300);
    endtask

    // From enable/reset release: speaker high on first edge, first
    // period_start after exactly 64 edges.
    task automatic startup(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_spk_first"}, int'(speaker), 1);
        end while (!period_start && n < 300);
        chk({tag, "_first_ps"}, n, 64);
    endtask

    initial begin
        int len;
        int hi;
        int exp_len[6];

        rst_n = 1'b0; en = 1'b0; oct_up = 1'b0; oct_dn = 1'b0;
        duty_sel = 2'd0; warble = 1'b0; w_up = 1'b0; w_dn = 1'b0;

        // ---- reset state
        @(negedge clk);
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_octave", int'(octave), 0);
        chk("rst_act", int'(act_octave), 0);
        chk("rst_pstart", int'(period_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- 1: octave 0, 50% duty
        en = 1'b1;
        startup("t1");
        measure(len, hi, -1, 2'd0);
        chk("t1_len_a", len, 64); chk("t1_hi_a", hi, 32);
        measure(len, hi, -1, 2'd0);
        chk("t1_len_b", len, 64); chk("t1_hi_b", hi, 32);

        // ---- 2: octave up at cycle 10 of a period
        repeat (10) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        chk("t2_octave", int'(octave), 1);
        chk("t2_act_hold", int'(act_octave), 0);
        wait_ps();
        chk("t2_act_after", int'(act_octave), 1);
        measure(len, hi, -1, 2'd0);
        chk("t2_len_a", len, 32); chk("t2_hi_a", hi, 16);
        measure(len, hi, -1, 2'd0);
        chk("t2_len_b", len, 32); chk("t2_hi_b", hi, 16);

        // ---- 3: saturate vs wrap
        repeat (5) pulse(1'b0, 1'b1, 1'b0);
        chk("t3_sat_top", int'(octave), 3);
        pulse(1'b0, 1'b1, 1'b1);
        chk("t3_both", int'(octave), 3);
        repeat (5) pulse(1'b1, 1'b1, 1'b0);
        chk("t3_wrap_up", int'(w_octave), 1);
        pulse(1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b1);
        chk("t3_wrap_dn", int'(w_octave), 3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t3_sat_dn", int'(octave), 2);

        // ---- 4: octave 2, 25% then 12.5% duty
        duty_sel = 2'd1;
        wait_ps();
        chk("t4_act", int'(act_octave), 2);
        measure(len, hi, -1, 2'd0);
        chk("t4_len_a", len, 16); chk("t4_hi_a", hi, 4);
        measure(len, hi, 3, 2'd2);
        chk("t4_len_sw", len, 16); chk("t4_hi_sw", hi, 4);
        measure(len, hi, -1, 2'd0);
        chk("t4_len_new", len, 16); chk("t4_hi_new", hi, 2);

        // ---- 5: warble on top octave
        duty_sel = 2'd0;
        pulse(1'b0, 1'b1, 1'b0);
        chk("t5_octave", int'(octave), 3);
        warble = 1'b1;
        wait_ps();
        exp_len = '{8, 8, 16, 16, 8, 8};
        for (int i = 0; i < 6; i++) begin
            measure(len, hi, -1, 2'd0);
            chk($sformatf("t5_len%0d", i), len, exp_len[i]);
            chk($sformatf("t5_hi%0d", i), hi, exp_len[i] / 2);
        end
        warble = 1'b0;
        measure(len, hi, -1, 2'd0);
        chk("t5_off_cur", len, 16);
        measure(len, hi, -1, 2'd0);
        chk("t5_off_a", len, 8);
        measure(len, hi, -1, 2'd0);
        chk("t5_off_b", len, 8);

        // ---- 6: async reset during a high phase
        @(negedge clk);
        chk("t6_pre_spk", int'(speaker), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_spk", int'(speaker), 0);
        chk("t6_async_oct", int'(octave), 0);
        chk("t6_async_act", int'(act_octave), 0);
        @(negedge clk);
        rst_n = 1'b1;
        startup("t6");
        measure(len, hi, -1, 2'd0);
        chk("t6_len", len, 64); chk("t6_hi", hi, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
